// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/handshake inputs and datapath controls of the multicycle controller
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state;
    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
               alu_src_a, alu_src_b, imm_src, reg_write, illegal, state
    );
    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
               alu_src_a, alu_src_b, imm_src, reg_write, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_ctrl #(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input logic              clk,
    input logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    logic [3:0] r_state, w_next;
    logic       r_illegal;
    logic [1:0] w_alu_op;
    logic [2:0] w_funct;
    logic       w_br_ok, w_taken;
    logic       w_pc_write, w_ir_write, w_mem_write, w_reg_write;
    always_ff @(posedge clk) begin
        r_state   <= reset ? S_FETCH : w_next;
        r_illegal <= reset ? 1'b0 : (r_illegal | (w_next == S_TRAP));
    end
    assign w_br_ok = (bus.funct3 == 3'b000) || (SUPPORT_BNE && (bus.funct3 == 3'b001));
    assign w_taken = w_br_ok && (bus.funct3[0] ? !bus.zero : bus.zero);
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                                 (bus.op == OP_R)   ? S_EXECR  :
                                 (bus.op == OP_I)   ? S_EXECI  :
                                 (bus.op == OP_BR)  ? S_BRANCH :
                                 (bus.op == OP_JAL) ? S_JAL    : S_TRAP;
            S_MEMADR:   w_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = w_br_ok ? S_FETCH : S_TRAP;
            S_JAL:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end
    always_comb begin
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        w_alu_op       = 2'b00;
        w_pc_write     = 1'b0;
        w_ir_write     = 1'b0;
        w_mem_write    = 1'b0;
        w_reg_write    = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                w_ir_write     = bus.mem_ready;
                w_pc_write     = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            S_MEMREAD:  bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'b01;
                w_reg_write    = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                bus.alu_src_a = 2'b10;
                w_alu_op      = 2'b10;
            end
            S_EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                w_alu_op      = 2'b10;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = 2'b10;
                w_alu_op      = 2'b01;
                w_pc_write    = w_taken;
            end
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                w_pc_write    = 1'b1;
            end
            default: ;
        endcase
    end
    // only R-type (op[5]) subtracts; instr[30] of an I-type is immediate data
    assign w_funct = (bus.funct3 == 3'b000) ? ((bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000) :
                     (bus.funct3 == 3'b010) ? 3'b101 :
                     (bus.funct3 == 3'b110) ? 3'b011 :
                     (bus.funct3 == 3'b111) ? 3'b010 : 3'b000;
    assign bus.alu_control = (w_alu_op == 2'b01) ? 3'b001 : (w_alu_op == 2'b10) ? w_funct : 3'b000;
    assign bus.imm_src     = (bus.op == OP_SW) ? 2'b01 : (bus.op == OP_BR) ? 2'b10 :
                             (bus.op == OP_JAL) ? 2'b11 : 2'b00;
    assign bus.pc_write    = w_pc_write & ~reset;
    assign bus.ir_write    = w_ir_write & ~reset;
    assign bus.mem_write   = w_mem_write & ~reset;
    assign bus.reg_write   = w_reg_write & ~reset;
    assign bus.illegal     = r_illegal;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for the multicycle control FSM (BNE enabled and disabled)
module tb_multicycle_ctrl;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
    typedef logic [20:0] obs_t;
    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       rdy;
        logic       rst;
    } stim_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    stim_t sq[$];
    obs_t  eq[$];
    string nq[$];
    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus2 ();
    multicycle_ctrl #(.SUPPORT_BNE(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    multicycle_ctrl #(.SUPPORT_BNE(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    assign bus2.op        = bus.op;
    assign bus2.funct3    = bus.funct3;
    assign bus2.funct7b5  = bus.funct7b5;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;
    always #5 clk = ~clk;
    // selects per state from the control table: {adr_src, result_src, alu_src_a, alu_src_b, imm_src}
    function automatic logic [8:0] mux_of(input logic [3:0] st, input logic [6:0] op);
        logic [6:0] m;
        logic [1:0] imm;
        case (st)
            4'd0:    m = 7'b0_10_00_10;
            4'd1:    m = 7'b0_00_01_01;
            4'd2:    m = 7'b0_00_10_01;
            4'd3:    m = 7'b1_00_00_00;
            4'd4:    m = 7'b0_01_00_00;
            4'd5:    m = 7'b1_00_00_00;
            4'd6:    m = 7'b0_00_10_00;
            4'd7:    m = 7'b0_00_10_01;
            4'd9:    m = 7'b0_00_10_00;
            4'd10:   m = 7'b0_00_01_10;
            default: m = 7'b0;
        endcase
        imm = (op == SW) ? 2'b01 : (op == BR) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
        return {m, imm};
    endfunction
    function automatic obs_t obs1();
        return {bus.state, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.alu_control,
                bus.illegal, bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src};
    endfunction
    function automatic obs_t obs2();
        return {bus2.state, bus2.pc_write, bus2.ir_write, bus2.mem_write, bus2.reg_write, bus2.alu_control,
                bus2.illegal, bus2.adr_src, bus2.result_src, bus2.alu_src_a, bus2.alu_src_b, bus2.imm_src};
    endfunction
    // en = {pc_write, ir_write, mem_write, reg_write}
    task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                        input logic rdy, input logic rst, input logic [3:0] st, input logic [3:0] en,
                        input logic [2:0] alu, input logic ill, input string n);
        stim_t s;
        s.op = op; s.f3 = f3; s.f7 = f7; s.z = z; s.rdy = rdy; s.rst = rst;
        sq.push_back(s);
        eq.push_back({st, en, alu, ill, mux_of(st, op)});
        nq.push_back(n);
    endtask
    task automatic apply(input stim_t s);
        bus.op = s.op; bus.funct3 = s.f3; bus.funct7b5 = s.f7;
        bus.zero = s.z; bus.mem_ready = s.rdy; reset = s.rst;
    endtask
    task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [3:0] ex_st, input logic [2:0] alu, input string n);
        push(op, f3, f7, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, {n, "/fetch"});
        push(op, f3, f7, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, {n, "/decode"});
        push(op, f3, f7, 0, 1, 0, ex_st, 4'b0000, alu, 0, {n, "/exec"});
        push(op, f3, f7, 0, 1, 0, 4'd8, 4'b0001, 3'b000, 0, {n, "/aluwb"});
    endtask
    task automatic test_reset();
        stim_t s; obs_t e, a; string n;
        push(RT, 3'b000, 0, 0, 1, 1, 4'd0, 4'b0000, 3'b000, 0, "reset/hold");
        push(RT, 3'b000, 0, 0, 0, 0, 4'd0, 4'b0000, 3'b000, 0, "reset/fetch_wait");
        while (eq.size() > 0) begin
            s = sq.pop_front(); e = eq.pop_front(); n = nq.pop_front();
            apply(s);
            @(negedge clk);
            a = obs1(); compared++;
            if (a !== e) begin mismatched++; $display("FAIL %s: got %h expected %h", n, a, e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_alu_ops();
        stim_t s; obs_t e, a; string n;
        alu_instr(RT, 3'b000, 0, 4'd6, 3'b000, "add");
        alu_instr(RT, 3'b000, 1, 4'd6, 3'b001, "sub");
        alu_instr(IT, 3'b000, 1, 4'd7, 3'b000, "addi_b30");
        alu_instr(RT, 3'b010, 0, 4'd6, 3'b101, "slt");
        alu_instr(IT, 3'b110, 0, 4'd7, 3'b011, "ori");
        alu_instr(RT, 3'b111, 0, 4'd6, 3'b010, "and");
        alu_instr(IT, 3'b100, 0, 4'd7, 3'b000, "xori_add");
        while (eq.size() > 0) begin
            s = sq.pop_front(); e = eq.pop_front(); n = nq.pop_front();
            apply(s);
            @(negedge clk);
            a = obs1(); compared++;
            if (a !== e) begin mismatched++; $display("FAIL %s: got %h expected %h", n, a, e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_memory();
        stim_t s; obs_t e, a; string n;
        push(LW, 3'b010, 0, 0, 0, 0, 4'd0, 4'b0000, 3'b000, 0, "lw/fetch_wait1");
        push(LW, 3'b010, 0, 0, 0, 0, 4'd0, 4'b0000, 3'b000, 0, "lw/fetch_wait2");
        push(LW, 3'b010, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "lw/fetch");
        push(LW, 3'b010, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "lw/decode");
        push(LW, 3'b010, 0, 0, 1, 0, 4'd2, 4'b0000, 3'b000, 0, "lw/memadr");
        for (int i = 0; i < 3; i++)
            push(LW, 3'b010, 0, 0, 0, 0, 4'd3, 4'b0000, 3'b000, 0, "lw/memread_wait");
        push(LW, 3'b010, 0, 0, 1, 0, 4'd3, 4'b0000, 3'b000, 0, "lw/memread");
        push(LW, 3'b010, 0, 0, 1, 0, 4'd4, 4'b0001, 3'b000, 0, "lw/memwb");
        push(SW, 3'b010, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "sw/fetch");
        push(SW, 3'b010, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "sw/decode");
        push(SW, 3'b010, 0, 0, 1, 0, 4'd2, 4'b0000, 3'b000, 0, "sw/memadr");
        push(SW, 3'b010, 0, 0, 0, 0, 4'd5, 4'b0010, 3'b000, 0, "sw/memwrite_wait1");
        push(SW, 3'b010, 0, 0, 0, 0, 4'd5, 4'b0010, 3'b000, 0, "sw/memwrite_wait2");
        push(SW, 3'b010, 0, 0, 1, 0, 4'd5, 4'b0010, 3'b000, 0, "sw/memwrite");
        push(SW, 3'b010, 0, 0, 0, 0, 4'd0, 4'b0000, 3'b000, 0, "sw/exit_once");
        push(SW, 3'b010, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "sw2/fetch");
        push(SW, 3'b010, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "sw2/decode");
        push(SW, 3'b010, 0, 0, 1, 0, 4'd2, 4'b0000, 3'b000, 0, "sw2/memadr");
        push(SW, 3'b010, 0, 0, 0, 0, 4'd5, 4'b0010, 3'b000, 0, "sw2/memwrite");
        push(SW, 3'b010, 0, 0, 0, 1, 4'd5, 4'b0000, 3'b000, 0, "sw2/reset_in_memwrite");
        push(RT, 3'b000, 0, 0, 0, 0, 4'd0, 4'b0000, 3'b000, 0, "sw2/after_reset");
        while (eq.size() > 0) begin
            s = sq.pop_front(); e = eq.pop_front(); n = nq.pop_front();
            apply(s);
            @(negedge clk);
            a = obs1(); compared++;
            if (a !== e) begin mismatched++; $display("FAIL %s: got %h expected %h", n, a, e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_branch_jal();
        stim_t s; obs_t e, a; string n;
        logic [2:0] f3;
        logic       z;
        for (int i = 0; i < 4; i++) begin
            f3 = (i < 2) ? 3'b000 : 3'b001;
            z = i[0];
            push(BR, f3, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "br/fetch");
            push(BR, f3, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "br/decode");
            push(BR, f3, 0, z, 1, 0, 4'd9, {(f3[0] ? !z : z), 3'b000}, 3'b001, 0, "br/branch");
        end
        push(JL, 3'b000, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "jal/fetch");
        push(JL, 3'b000, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "jal/decode");
        push(JL, 3'b000, 0, 1, 1, 0, 4'd10, 4'b1000, 3'b000, 0, "jal/jal");
        push(JL, 3'b000, 0, 0, 1, 0, 4'd8, 4'b0001, 3'b000, 0, "jal/aluwb");
        alu_instr(RT, 3'b000, 0, 4'd6, 3'b000, "b2b_add");
        while (eq.size() > 0) begin
            s = sq.pop_front(); e = eq.pop_front(); n = nq.pop_front();
            apply(s);
            @(negedge clk);
            a = obs1(); compared++;
            if (a !== e) begin mismatched++; $display("FAIL %s: got %h expected %h", n, a, e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_trap();
        stim_t s; obs_t e, a; string n;
        push(BAD, 3'b000, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "trap/fetch");
        push(BAD, 3'b000, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "trap/decode");
        for (int i = 0; i < 20; i++)
            push(BAD, 3'b000, 0, 0, 1, 0, 4'd11, 4'b0000, 3'b000, 1, "trap/sticky");
        push(BAD, 3'b000, 0, 0, 1, 1, 4'd11, 4'b0000, 3'b000, 1, "trap/reset_cycle");
        push(BR, 3'b100, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "blt/fetch");
        push(BR, 3'b100, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "blt/decode");
        push(BR, 3'b100, 0, 1, 1, 0, 4'd9, 4'b0000, 3'b001, 0, "blt/branch");
        push(BR, 3'b100, 0, 1, 1, 0, 4'd11, 4'b0000, 3'b000, 1, "blt/trap");
        push(BR, 3'b100, 0, 1, 1, 1, 4'd11, 4'b0000, 3'b000, 1, "blt/reset_cycle");
        alu_instr(RT, 3'b000, 1, 4'd6, 3'b001, "post_reset_sub");
        while (eq.size() > 0) begin
            s = sq.pop_front(); e = eq.pop_front(); n = nq.pop_front();
            apply(s);
            @(negedge clk);
            a = obs1(); compared++;
            if (a !== e) begin mismatched++; $display("FAIL %s: got %h expected %h", n, a, e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_no_bne();
        stim_t s; obs_t e, a; string n;
        push(BR, 3'b000, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "nobne_beq/fetch");
        push(BR, 3'b000, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "nobne_beq/decode");
        push(BR, 3'b000, 0, 1, 1, 0, 4'd9, 4'b1000, 3'b001, 0, "nobne_beq/branch");
        push(BR, 3'b001, 0, 0, 1, 0, 4'd0, 4'b1100, 3'b000, 0, "nobne_bne/fetch");
        push(BR, 3'b001, 0, 0, 1, 0, 4'd1, 4'b0000, 3'b000, 0, "nobne_bne/decode");
        push(BR, 3'b001, 0, 0, 1, 0, 4'd9, 4'b0000, 3'b001, 0, "nobne_bne/branch");
        for (int i = 0; i < 3; i++)
            push(BR, 3'b001, 0, 0, 1, 0, 4'd11, 4'b0000, 3'b000, 1, "nobne_bne/trap");
        while (eq.size() > 0) begin
            s = sq.pop_front(); e = eq.pop_front(); n = nq.pop_front();
            apply(s);
            @(negedge clk);
            a = obs2(); compared++;
            if (a !== e) begin mismatched++; $display("FAIL %s: got %h expected %h", n, a, e); end
            @(posedge clk); #1;
        end
    endtask
    initial begin
        bus.op = RT; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu_ops();
        test_memory();
        test_branch_jal();
        test_trap();
        test_no_bne();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
